vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//  Transaction sequencer for the vending front end: accumulates coin credit in quarter units,
//  accepts a product selection and checks it against a price table, then handshakes the
//  dispense motor and returns change one quarter at a time via the coin ejector.
//  Sits between the coin acceptor / keypad and the motor and ejector actuators.
// PARAMETERS
//  NUM_PROD    4    number of products; sel_id/disp_id width = $clog2(NUM_PROD)
//  MAX_CREDIT  8    credit ceiling in quarters ($2.00); credit width CW = $clog2(MAX_CREDIT+1)
//  DISP_TO     255  cycles to wait for disp_done before faulting
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high
//  coin       in   3            000 none, 001 quarter, 010 fifty, 100 dollar; one coin per non-zero cycle
//  sel_valid  in   1            selection strobe, 1 cycle
//  sel_id     in   $clog2(NP)   product index, sampled with sel_valid
//  cancel     in   1            refund request, 1 cycle
//  price_tbl  in   NP*4         per-product price in quarters, product i at [4i+:4]; static during a vend
//  disp_req   out  1            motor request, held until disp_done
//  disp_id    out  $clog2(NP)   product being dispensed, stable while disp_req=1
//  disp_done  in   1            motor completion, 1 cycle
//  eject_req  out  1            eject one quarter, held until eject_ack
//  eject_ack  in   1            one quarter ejected, 1 cycle
//  credit     out  CW           current credit in quarters
//  coin_rej   out  1            1-cycle pulse: coin refused
//  sel_rej    out  1            1-cycle pulse: selection refused (low credit, bad id, price 0)
//  fault      out  1            sticky motor timeout; cleared only by reset
// BEHAVIOUR
//  - Reset (asynchronous): state IDLE, credit=0; every output 0.
//  - States: IDLE (credit=0), CREDIT (credit>0), VEND (disp_req=1), CHANGE (eject_req=1), FAULT.
//  - Coin values: quarter=1, fifty=2, dollar=4. Illegal codes (011,101,110,111) -> coin_rej, credit unchanged.
//  - Coin accepted only in IDLE/CREDIT. Credit += value on the next edge when credit+value <= MAX_CREDIT;
//    otherwise coin_rej and credit unchanged. In VEND/CHANGE/FAULT every non-zero coin -> coin_rej.
//  - IDLE -> CREDIT on the first accepted coin. CREDIT -> IDLE never happens by coins alone.
//  - Selection in IDLE/CREDIT: if sel_id < NP, price != 0 and credit >= price: credit -= price,
//    disp_id = sel_id, disp_req=1 from the next cycle, -> VEND. Otherwise sel_rej, no state change.
//  - Same cycle, coin and sel_valid: the coin is processed first; the selection is checked against the
//    updated credit. Selection has priority over cancel; cancel is ignored that cycle.
//  - cancel in CREDIT -> CHANGE with the full credit refunded. cancel in IDLE is a no-op.
//  - VEND: disp_req held high. On disp_done -> CHANGE if credit>0, else IDLE; disp_req drops the next cycle.
//    Timeout counter starts at 0 on VEND entry. At DISP_TO cycles without disp_done -> FAULT:
//    fault=1, disp_req=0, credit kept.
//  - CHANGE: eject_req held high. Each eject_ack decrements credit by 1. When credit reaches 0 ->
//    IDLE, and eject_req is 0 that same cycle. No eject timeout.
//  - FAULT: absorbing. All coins rejected; sel and cancel ignored.
//  - disp_done or eject_ack outside its own state is ignored.
//  - sel_rej and coin_rej are registered, asserted the cycle after the cause, never stretched.
//  - Reset mid-vend or mid-change drops requests at once and clears credit (credit is lost by design).
// STRUCTURE
//  - vend_pkg: coin code localparams (COIN_NONE/Q/F/D), typedef enum vend_state_t, function
//    coin_value(logic [2:0]) returning quarters, 0 for illegal codes.
//  - One sub-module, vend_credit_acc: credit register with add/subtract/saturation check and coin_rej
//    generation. The sequencer FSM and timeout counter stay in the top.
// TESTING
//  1 reset; coin 001,010,100 on consecutive cycles -> credit 1,3,7; state CREDIT; no rejects.
//  2 credit 7, coin 010 (MAX 8) -> coin_rej pulse, credit stays 7; coin 011 -> coin_rej, credit 7.
//  3 price_tbl[1]=5, credit 7, sel_id=1 -> disp_req=1, disp_id=1, credit 2; disp_done -> 2 eject
//    handshakes -> credit 0, IDLE.
//  4 credit 2, sel_id=1 (price 5) -> sel_rej, credit 2; same cycle coin 100 + sel_id=1 -> credit 6-5=1, VEND.
//  5 credit 3, cancel -> CHANGE, 3 eject_ack -> IDLE; coins during CHANGE -> coin_rej every time.
//  6 VEND, withhold disp_done DISP_TO cycles -> fault=1, disp_req=0; assert reset mid-VEND -> all outputs 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: coin codes, FSM states, coin valuation.
package vend_pkg;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_Q    = 3'b001;
    localparam logic [2:0] COIN_F    = 3'b010;
    localparam logic [2:0] COIN_D    = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StCredit,
        StVend,
        StChange,
        StFault
    } vend_state_t;

    // Value of a coin code in quarters; 0 marks an illegal or empty code.
    function automatic logic [2:0] coin_value(input logic [2:0] code);
        logic [2:0] val;
        case (code)
            COIN_Q:  val = 3'd1;
            COIN_F:  val = 3'd2;
            COIN_D:  val = 3'd4;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: adds accepted coins, subtracts a vend price, steps down on each eject.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 8,
    parameter int unsigned CW         = $clog2(MAX_CREDIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    coin_i,
    input  logic          coin_ok_i,
    input  logic          sub_en_i,
    input  logic [CW-1:0] sub_amt_i,
    input  logic          dec_en_i,
    output logic [CW-1:0] credit_o,
    output logic [CW-1:0] credit_coin_o,
    output logic          coin_rej_o
);

    logic [CW-1:0] credit_q, credit_d;
    logic          coin_rej_q, coin_rej_d;
    logic [CW-1:0] credit_coin;
    logic [CW:0]   sum;
    logic [2:0]    val;
    logic          add_ok;

    // Coin first, then any same-cycle vend price comes out of the updated credit.
    always_comb begin
        val         = coin_value(coin_i);
        sum         = {1'b0, credit_q} + (CW + 1)'(val);
        add_ok      = coin_ok_i && (val != 3'd0) && (sum <= (CW + 1)'(MAX_CREDIT));
        credit_coin = add_ok ? sum[CW-1:0] : credit_q;
        coin_rej_d  = (coin_i != COIN_NONE) && !add_ok;
        credit_d    = credit_coin;
        if (sub_en_i) begin
            credit_d = credit_coin - sub_amt_i;
        end else if (dec_en_i && (credit_q != '0)) begin
            credit_d = credit_q - CW'(1);
        end
    end

    // Credit and reject pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign credit_o      = credit_q;
    assign credit_coin_o = credit_coin;
    assign coin_rej_o    = coin_rej_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: credit, selection, dispense handshake and change return.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned NUM_PROD   = 4,
    parameter int unsigned MAX_CREDIT = 8,
    parameter int unsigned DISP_TO    = 255,
    localparam int unsigned IW        = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1,
    localparam int unsigned CW        = $clog2(MAX_CREDIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            coin,
    input  logic                  sel_valid,
    input  logic [IW-1:0]         sel_id,
    input  logic                  cancel,
    input  logic [NUM_PROD*4-1:0] price_tbl,
    output logic                  disp_req,
    output logic [IW-1:0]         disp_id,
    input  logic                  disp_done,
    output logic                  eject_req,
    input  logic                  eject_ack,
    output logic [CW-1:0]         credit,
    output logic                  coin_rej,
    output logic                  sel_rej,
    output logic                  fault
);

    localparam int unsigned TW   = $clog2(DISP_TO + 1);
    localparam int unsigned CmpW = (CW > 4) ? CW : 4;

    vend_state_t   state_q, state_d;
    logic          disp_req_q, disp_req_d;
    logic [IW-1:0] disp_id_q, disp_id_d;
    logic          eject_req_q, eject_req_d;
    logic          sel_rej_q, sel_rej_d;
    logic          fault_q, fault_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic          accept_st;
    logic [3:0]    sel_price;
    logic          sel_ok;
    logic [CW-1:0] credit_coin;

    assign accept_st = (state_q == StIdle) || (state_q == StCredit);

    // Price lookup; ids beyond the table read as price 0 and are refused.
    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_id == IW'(i)) begin
                sel_price = price_tbl[4*i +: 4];
            end
        end
        sel_ok = accept_st && sel_valid && (32'(sel_id) < NUM_PROD) && (sel_price != 4'd0) &&
                 (CmpW'(credit_coin) >= CmpW'(sel_price));
    end

    vend_credit_acc #(
        .MAX_CREDIT (MAX_CREDIT),
        .CW         (CW)
    ) u_credit (
        .clk           (clk),
        .reset         (reset),
        .coin_i        (coin),
        .coin_ok_i     (accept_st),
        .sub_en_i      (sel_ok),
        .sub_amt_i     (CW'(sel_price)),
        .dec_en_i      ((state_q == StChange) && eject_ack),
        .credit_o      (credit),
        .credit_coin_o (credit_coin),
        .coin_rej_o    (coin_rej)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        disp_req_d  = disp_req_q;
        disp_id_d   = disp_id_q;
        eject_req_d = eject_req_q;
        sel_rej_d   = 1'b0;
        fault_d     = fault_q;
        to_cnt_d    = to_cnt_q;
        unique case (state_q)
            StIdle, StCredit: begin
                if (sel_valid) begin
                    if (sel_ok) begin
                        state_d    = StVend;
                        disp_req_d = 1'b1;
                        disp_id_d  = sel_id;
                        to_cnt_d   = '0;
                    end else begin
                        sel_rej_d = 1'b1;
                        state_d   = (credit_coin != '0) ? StCredit : StIdle;
                    end
                end else if (cancel && (state_q == StCredit)) begin
                    state_d     = StChange;
                    eject_req_d = 1'b1;
                end else begin
                    state_d = (credit_coin != '0) ? StCredit : StIdle;
                end
            end
            StVend: begin
                if (disp_done) begin
                    disp_req_d = 1'b0;
                    if (credit != '0) begin
                        state_d     = StChange;
                        eject_req_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (to_cnt_q == TW'(DISP_TO - 1)) begin
                    state_d    = StFault;
                    disp_req_d = 1'b0;
                    fault_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            StChange: begin
                // Last quarter out: request drops together with credit reaching 0.
                if (eject_ack && (credit == CW'(1))) begin
                    state_d     = StIdle;
                    eject_req_d = 1'b0;
                end
            end
            StFault: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            disp_req_q  <= 1'b0;
            disp_id_q   <= '0;
            eject_req_q <= 1'b0;
            sel_rej_q   <= 1'b0;
            fault_q     <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            disp_req_q  <= disp_req_d;
            disp_id_q   <= disp_id_d;
            eject_req_q <= eject_req_d;
            sel_rej_q   <= sel_rej_d;
            fault_q     <= fault_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign disp_req  = disp_req_q;
    assign disp_id   = disp_id_q;
    assign eject_req = eject_req_q;
    assign sel_rej   = sel_rej_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_vend_sequencer;

    localparam int NP   = 4;
    localparam int MAXC = 8;
    localparam int DTO  = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  coin;
    logic        sel_valid;
    logic [1:0]  sel_id;
    logic        cancel;
    logic [15:0] price_tbl;
    logic        disp_req;
    logic [1:0]  disp_id;
    logic        disp_done;
    logic        eject_req;
    logic        eject_ack;
    logic [3:0]  credit;
    logic        coin_rej;
    logic        sel_rej;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_credit;
    bit m_vend, m_chg, m_fault, m_crej, m_srej;
    int m_wait, m_id;

    vend_sequencer #(
        .NUM_PROD   (NP),
        .MAX_CREDIT (MAXC),
        .DISP_TO    (DTO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .coin      (coin),
        .sel_valid (sel_valid),
        .sel_id    (sel_id),
        .cancel    (cancel),
        .price_tbl (price_tbl),
        .disp_req  (disp_req),
        .disp_id   (disp_id),
        .disp_done (disp_done),
        .eject_req (eject_req),
        .eject_ack (eject_ack),
        .credit    (credit),
        .coin_rej  (coin_rej),
        .sel_rej   (sel_rej),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int coin_val(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int price_of(input int id);
        return int'((price_tbl >> (4 * id)) & 16'hF);
    endfunction

    task automatic model_reset();
        m_credit = 0; m_vend = 0; m_chg = 0; m_fault = 0;
        m_crej = 0; m_srej = 0; m_wait = 0; m_id = 0;
    endtask

    // One clock of transaction behaviour: what the outputs should be after this edge.
    task automatic model_update(input logic [2:0] c, input bit sv, input int id, input bit cn,
                                input bit dd, input bit ea);
        int v, pr, c0;
        m_crej = 0;
        m_srej = 0;
        if (m_fault) begin
            if (c != 0) m_crej = 1;
        end else if (m_vend) begin
            if (c != 0) m_crej = 1;
            if (dd) begin
                m_vend = 0;
                m_chg  = (m_credit > 0);
            end else begin
                m_wait++;
                if (m_wait == DTO) begin
                    m_vend  = 0;
                    m_fault = 1;
                end
            end
        end else if (m_chg) begin
            if (c != 0) m_crej = 1;
            if (ea) begin
                m_credit--;
                if (m_credit == 0) m_chg = 0;
            end
        end else begin
            c0 = m_credit;
            v  = coin_val(c);
            if (c != 0) begin
                if (v == 0 || m_credit + v > MAXC) m_crej = 1;
                else m_credit += v;
            end
            if (sv) begin
                pr = price_of(id);
                if (id < NP && pr != 0 && m_credit >= pr) begin
                    m_credit -= pr;
                    m_vend = 1;
                    m_wait = 0;
                    m_id   = id;
                end else begin
                    m_srej = 1;
                end
            end else if (cn && c0 > 0) begin
                m_chg = 1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("credit", credit, m_credit);
        check_eq("disp_req", disp_req, m_vend);
        if (m_vend) check_eq("disp_id", disp_id, m_id);
        check_eq("eject_req", eject_req, m_chg);
        check_eq("coin_rej", coin_rej, m_crej);
        check_eq("sel_rej", sel_rej, m_srej);
        check_eq("fault", fault, m_fault);
    endtask

    task automatic step(input logic [2:0] c, input bit sv, input int id, input bit cn,
                        input bit dd, input bit ea);
        coin = c; sel_valid = sv; sel_id = id[1:0]; cancel = cn; disp_done = dd; eject_ack = ea;
        model_update(c, sv, id, cn, dd, ea);
        @(posedge clk);
        #1;
        coin = 3'b000; sel_valid = 0; cancel = 0; disp_done = 0; eject_ack = 0;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1;
        coin = 3'b000; sel_valid = 0; sel_id = 0; cancel = 0; disp_done = 0; eject_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_credit", credit, 0);
        check_eq("rst_disp_req", disp_req, 0);
        check_eq("rst_eject_req", eject_req, 0);
        check_eq("rst_fault", fault, 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        int r, id, hi_cnt;
        logic [2:0] c;
        bit sv, cn, dd, ea;

        price_tbl = 16'h0253;  // prices: p0=3, p1=5, p2=2, p3=0
        model_reset();
        apply_reset();

        // 1: coins accumulate 1, 3, 7
        step(3'b001, 0, 0, 0, 0, 0); check_eq("t1_credit1", credit, 1);
        step(3'b010, 0, 0, 0, 0, 0); check_eq("t1_credit3", credit, 3);
        step(3'b100, 0, 0, 0, 0, 0); check_eq("t1_credit7", credit, 7);

        // 2: overflow and illegal code refused
        step(3'b010, 0, 0, 0, 0, 0); check_eq("t2_ovf_rej", coin_rej, 1); check_eq("t2_c7", credit, 7);
        step(3'b011, 0, 0, 0, 0, 0); check_eq("t2_ill_rej", coin_rej, 1); check_eq("t2_c7b", credit, 7);
        idle_steps(1);

        // 3: vend product 1, then two quarters of change
        step(3'b000, 1, 1, 0, 0, 0);
        check_eq("t3_disp_req", disp_req, 1); check_eq("t3_disp_id", disp_id, 1);
        check_eq("t3_credit", credit, 2);
        idle_steps(3);
        step(3'b000, 0, 0, 0, 1, 0); check_eq("t3_eject_req", eject_req, 1);
        idle_steps(2);
        step(3'b000, 0, 0, 0, 0, 1);
        idle_steps(1);
        step(3'b000, 0, 0, 0, 0, 1);
        check_eq("t3_credit0", credit, 0); check_eq("t3_eject_off", eject_req, 0);

        // 4: low credit refused, then coin + select in the same cycle; price-0 product refused
        step(3'b010, 0, 0, 0, 0, 0);
        step(3'b000, 1, 1, 0, 0, 0); check_eq("t4_sel_rej", sel_rej, 1); check_eq("t4_c2", credit, 2);
        step(3'b000, 1, 3, 0, 0, 0); check_eq("t4_p0_rej", sel_rej, 1);
        step(3'b100, 1, 1, 1, 0, 0); check_eq("t4_credit1", credit, 1);
        check_eq("t4_vend", disp_req, 1);
        step(3'b000, 0, 0, 0, 1, 0);
        step(3'b000, 0, 0, 0, 0, 1);

        // 5: cancel refunds everything; coins during change are refused
        step(3'b001, 0, 0, 0, 0, 0);
        step(3'b010, 0, 0, 0, 0, 0);
        step(3'b000, 0, 0, 1, 0, 0); check_eq("t5_eject_req", eject_req, 1);
        step(3'b001, 0, 0, 0, 0, 1); check_eq("t5_rej1", coin_rej, 1);
        step(3'b100, 0, 0, 0, 0, 1); check_eq("t5_rej2", coin_rej, 1);
        step(3'b000, 0, 0, 0, 0, 1); check_eq("t5_idle", eject_req, 0);
        step(3'b000, 0, 0, 1, 0, 0);  // cancel with no credit does nothing

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0 && !m_vend) begin
                for (int i = 0; i < NP; i++) price_tbl[4*i +: 4] = 4'($urandom_range(0, 8));
            end
            r = $urandom % 16;
            if (r < 9) c = 3'b000;
            else if (r < 11) c = 3'b001;
            else if (r < 13) c = 3'b010;
            else if (r == 13) c = 3'b100;
            else if (r == 14) c = 3'b011;
            else c = 3'($urandom_range(5, 7));
            sv = ($urandom % 12) == 0;
            id = $urandom_range(0, NP - 1);
            cn = ($urandom % 16) == 0;
            dd = m_vend ? (($urandom % 4) == 0) : (($urandom % 20) == 0);
            ea = m_chg ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
            step(c, sv, id, cn, dd, ea);
        end

        // 6: dispense timeout, then absorbing fault
        price_tbl = 16'h0253;
        apply_reset();
        step(3'b100, 0, 0, 0, 0, 0);
        step(3'b000, 1, 0, 0, 0, 0);
        hi_cnt = 0;
        for (int i = 0; i < DTO + 5; i++) begin
            if (disp_req) hi_cnt++;
            step(3'b000, 0, 0, 0, 0, 0);
        end
        check_eq("t6_req_cycles", hi_cnt, DTO);
        check_eq("t6_fault", fault, 1); check_eq("t6_disp_off", disp_req, 0);
        check_eq("t6_credit_kept", credit, 1);
        step(3'b001, 1, 0, 1, 0, 0); check_eq("t6_coin_rej", coin_rej, 1);
        check_eq("t6_sel_ign", sel_rej, 0);

        // Reset asserted mid-vend drops everything immediately
        apply_reset();
        step(3'b100, 0, 0, 0, 0, 0);
        step(3'b000, 1, 0, 0, 0, 0);
        step(3'b000, 0, 0, 0, 0, 0);
        check_eq("t6_pre_vend", disp_req, 1);
        #3;
        reset = 1;
        #1;
        check_eq("t6_async_req", disp_req, 0);
        check_eq("t6_async_credit", credit, 0);
        check_eq("t6_async_eject", eject_req, 0);
        check_eq("t6_async_fault", fault, 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        idle_steps(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
